// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline constants: FSM encoding, default sizes and the
// per-cycle pipeline-register control word with its canned values.
package pipeline_ctrl_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 63;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctl_t;

  // Freeze keeps PC/IFID, pushes a bubble into IDEX and lets the back end drain.
  localparam ctl_t CTL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CTL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory status into the controller and register controls plus
// status counters back out to the datapath.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             freez;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             clr_cnt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output freez, branch_taken, mem_req, mem_ready, clr_cnt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  freez, branch_taken, mem_req, mem_ready, clr_cnt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, mem_err, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout abort,
// branch/hazard decode of register enables, and stall/flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             mem_err_q, mem_err_d;
  logic             advance;
  ctl_t             ctl;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    advance   = 1'b0;
    ctl       = CTL_HOLD;

    unique case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
          advance = 1'b1;
        end else if (wcnt_q == WCNT_LAST) begin
          // Access abandoned: flag it and let the pipeline move on.
          state_d   = RUN;
          mem_err_d = 1'b1;
          advance   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase

    if (advance) begin
      if (bus.branch_taken)  ctl = CTL_BRANCH;
      else if (bus.freez)    ctl = CTL_FREEZE;
      else                   ctl = CTL_RUN;
    end

    if (rst) ctl = CTL_RESET;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst | bus.clr_cnt),
    .inc_i (~ctl.pc_en),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst | bus.clr_cnt),
    .inc_i (ctl.ifid_flush),
    .cnt_o (flush_cnt)
  );

  assign bus.pc_en        = ctl.pc_en;
  assign bus.ifid_en      = ctl.ifid_en;
  assign bus.idex_en      = ctl.idex_en;
  assign bus.exmem_en     = ctl.exmem_en;
  assign bus.memwb_en     = ctl.memwb_en;
  assign bus.ifid_flush   = ctl.ifid_flush;
  assign bus.idex_flush   = ctl.idex_flush;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;

endmodule
